// File: rtl/wb_write_scheduler.sv
// ---------------------------------------------------------------------------
// wb_write_scheduler
//   Write-back scheduler sitting directly in front of the dual-write-port
//   register file. Takes up to two results per cycle (ALU = older, load =
//   younger) and maps them onto the two register write ports. Two writes to
//   the same register are never issued in one cycle; the younger one is
//   deferred through an in-order pending FIFO so that per-register program
//   order is preserved. All port outputs are registered (accept in N, write
//   visible in N+1).
//
// Ports
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   alu_Valid/Addr/Data ALU result (older of the pair)
//   mem_Valid/Addr/Data load result (younger of the pair)
//   wb_Ready            room for two more requests
//   in_Reg, reg_Write   port-0 write data / one-hot enables
//   in_Reg1, reg_Write1 port-1 write data / one-hot enables
//   pend_Count          pending FIFO occupancy
//   ovf_Err             sticky: request seen while wb_Ready was low
// ---------------------------------------------------------------------------
module wb_write_scheduler #(
    parameter int DATA_W     = 16,
    parameter int NREG       = 8,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              alu_Valid,
    input  logic [ADDR_W-1:0] alu_Addr,
    input  logic [DATA_W-1:0] alu_Data,
    input  logic              mem_Valid,
    input  logic [ADDR_W-1:0] mem_Addr,
    input  logic [DATA_W-1:0] mem_Data,
    output logic              wb_Ready,
    output logic [DATA_W-1:0] in_Reg,
    output logic [NREG-1:0]   reg_Write,
    output logic [DATA_W-1:0] in_Reg1,
    output logic [NREG-1:0]   reg_Write1,
    output logic [ADDR_W:0]   pend_Count,
    output logic              ovf_Err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    typedef logic [ADDR_W:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // Pending FIFO storage (data only, never reset: occupancy lives in cnt_q)
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    ptr_t              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    ptr_t              sec_ptr, wr_ptr1;
    cnt_t              cnt_q, cnt_d, push_n, pop_n;
    logic              rdy_q, rdy_d, ovf_q, ovf_d;
    logic              acc_alu, acc_mem;
    logic [ADDR_W-1:0] push0_addr, push1_addr;
    logic [DATA_W-1:0] push0_data, push1_data;
    logic [NREG-1:0]   we0_q, we0_d, we1_q, we1_d;
    logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
        return NREG'(1) << a;
    endfunction

    always_comb begin
        acc_alu    = alu_Valid & rdy_q;
        acc_mem    = mem_Valid & rdy_q;
        we0_d      = '0;
        dat0_d     = '0;
        we1_d      = '0;
        dat1_d     = '0;
        push_n     = '0;
        pop_n      = '0;
        push0_addr = alu_Addr;
        push0_data = alu_Data;
        push1_addr = mem_Addr;
        push1_data = mem_Data;
        sec_ptr    = ptr_inc(rd_ptr_q);
        wr_ptr1    = ptr_inc(wr_ptr_q);

        if (cnt_q == '0) begin
            // Bypass: issue straight to the ports, defer only a same-register load
            if (acc_alu) begin
                we0_d  = onehot(alu_Addr);
                dat0_d = alu_Data;
                if (acc_mem) begin
                    if (mem_Addr != alu_Addr) begin
                        we1_d  = onehot(mem_Addr);
                        dat1_d = mem_Data;
                    end else begin
                        push0_addr = mem_Addr;
                        push0_data = mem_Data;
                        push_n     = cnt_t'(1);
                    end
                end
            end else if (acc_mem) begin
                we0_d  = onehot(mem_Addr);
                dat0_d = mem_Data;
            end
        end else begin
            // Drain: older queued writes go first, new arrivals queue behind them
            we0_d  = onehot(fifo_addr_q[rd_ptr_q]);
            dat0_d = fifo_data_q[rd_ptr_q];
            pop_n  = cnt_t'(1);
            if (cnt_q >= cnt_t'(2) && fifo_addr_q[sec_ptr] != fifo_addr_q[rd_ptr_q]) begin
                we1_d  = onehot(fifo_addr_q[sec_ptr]);
                dat1_d = fifo_data_q[sec_ptr];
                pop_n  = cnt_t'(2);
            end
            if (acc_alu && acc_mem) begin
                push_n = cnt_t'(2);
            end else if (acc_alu) begin
                push_n = cnt_t'(1);
            end else if (acc_mem) begin
                push0_addr = mem_Addr;
                push0_data = mem_Data;
                push_n     = cnt_t'(1);
            end
        end

        cnt_d = cnt_q - pop_n + push_n;

        case (pop_n)
            cnt_t'(1): rd_ptr_d = sec_ptr;
            cnt_t'(2): rd_ptr_d = ptr_inc(sec_ptr);
            default:   rd_ptr_d = rd_ptr_q;
        endcase
        case (push_n)
            cnt_t'(1): wr_ptr_d = wr_ptr1;
            cnt_t'(2): wr_ptr_d = ptr_inc(wr_ptr1);
            default:   wr_ptr_d = wr_ptr_q;
        endcase

        rdy_d = (int'(cnt_d) + 2) <= FIFO_DEPTH;
        ovf_d = ovf_q | ((alu_Valid | mem_Valid) & ~rdy_q);
    end

    // Registered port outputs and FIFO control
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b1;
            ovf_q    <= 1'b0;
            we0_q    <= '0;
            dat0_q   <= '0;
            we1_q    <= '0;
            dat1_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            ovf_q    <= ovf_d;
            we0_q    <= we0_d;
            dat0_q   <= dat0_d;
            we1_q    <= we1_d;
            dat1_q   <= dat1_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_n != '0) begin
            fifo_addr_q[wr_ptr_q] <= push0_addr;
            fifo_data_q[wr_ptr_q] <= push0_data;
        end
        if (push_n == cnt_t'(2)) begin
            fifo_addr_q[wr_ptr1] <= push1_addr;
            fifo_data_q[wr_ptr1] <= push1_data;
        end
    end

    assign wb_Ready   = rdy_q;
    assign in_Reg     = dat0_q;
    assign reg_Write  = we0_q;
    assign in_Reg1    = dat1_q;
    assign reg_Write1 = we1_q;
    assign pend_Count = cnt_q;
    assign ovf_Err    = ovf_q;

endmodule

// File: tb/tb_wb_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wb_write_scheduler
//   Directed scenarios plus randomized traffic for wb_write_scheduler,
//   checked against a queue-based model of the scheduling rules.
// ---------------------------------------------------------------------------
module tb_wb_write_scheduler;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              alu_Valid = 1'b0;
    logic [ADDR_W-1:0] alu_Addr = '0;
    logic [DATA_W-1:0] alu_Data = '0;
    logic              mem_Valid = 1'b0;
    logic [ADDR_W-1:0] mem_Addr = '0;
    logic [DATA_W-1:0] mem_Data = '0;
    logic              wb_Ready;
    logic [DATA_W-1:0] in_Reg, in_Reg1;
    logic [NREG-1:0]   reg_Write, reg_Write1;
    logic [ADDR_W:0]   pend_Count;
    logic              ovf_Err;

    always #5 Clk = ~Clk;

    wb_write_scheduler #(
        .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .alu_Valid(alu_Valid), .alu_Addr(alu_Addr), .alu_Data(alu_Data),
        .mem_Valid(mem_Valid), .mem_Addr(mem_Addr), .mem_Data(mem_Data),
        .wb_Ready(wb_Ready),
        .in_Reg(in_Reg), .reg_Write(reg_Write),
        .in_Reg1(in_Reg1), .reg_Write1(reg_Write1),
        .pend_Count(pend_Count), .ovf_Err(ovf_Err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    // Reference model state
    wr_t             pq[$];
    bit              m_rdy;
    bit              m_ovf;
    logic [NREG-1:0] e_we0, e_we1;
    logic [DATA_W-1:0] e_d0, e_d1;

    // Register contents as seen through the DUT write ports
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] r3_log[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        m_rdy = 1'b1;
        m_ovf = 1'b0;
        e_we0 = '0; e_we1 = '0; e_d0 = '0; e_d1 = '0;
    endtask

    // One clock of scheduling: requests, then what each port should carry next cycle
    task automatic model_eval();
        wr_t acc[$];
        wr_t w, p0, p1;
        bit  u0, u1;
        u0 = 0; u1 = 0; p0 = '0; p1 = '0;
        if ((alu_Valid || mem_Valid) && !m_rdy) m_ovf = 1'b1;
        if (m_rdy && alu_Valid) begin w.a = alu_Addr; w.d = alu_Data; acc.push_back(w); end
        if (m_rdy && mem_Valid) begin w.a = mem_Addr; w.d = mem_Data; acc.push_back(w); end
        if (pq.size() == 0) begin
            if (acc.size() > 0) begin p0 = acc.pop_front(); u0 = 1; end
            if (acc.size() > 0) begin
                if (acc[0].a != p0.a) begin p1 = acc.pop_front(); u1 = 1; end
                else pq.push_back(acc.pop_front());
            end
        end else begin
            p0 = pq.pop_front(); u0 = 1;
            if (pq.size() > 0 && pq[0].a != p0.a) begin p1 = pq.pop_front(); u1 = 1; end
            foreach (acc[i]) pq.push_back(acc[i]);
        end
        e_we0 = u0 ? (NREG'(1) << p0.a) : '0;
        e_d0  = u0 ? p0.d : '0;
        e_we1 = u1 ? (NREG'(1) << p1.a) : '0;
        e_d1  = u1 ? p1.d : '0;
        m_rdy = (DEPTH - pq.size()) >= 2;
    endtask

    task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
        alu_Valid = av; alu_Addr = aa; alu_Data = ad;
        mem_Valid = mv; mem_Addr = ma; mem_Data = md;
        model_eval();
        @(posedge Clk);
        #1;
        check("reg_Write",  32'(reg_Write),  32'(e_we0));
        check("in_Reg",     32'(in_Reg),     32'(e_d0));
        check("reg_Write1", 32'(reg_Write1), 32'(e_we1));
        check("in_Reg1",    32'(in_Reg1),    32'(e_d1));
        check("pend_Count", 32'(pend_Count), 32'(pq.size()));
        check("wb_Ready",   32'(wb_Ready),   32'(m_rdy));
        check("ovf_Err",    32'(ovf_Err),    32'(m_ovf));
        check("port_overlap", 32'(reg_Write & reg_Write1), 32'(0));
        for (int i = 0; i < NREG; i++) begin
            if (reg_Write[i])  rf[i] = in_Reg;
            if (reg_Write1[i]) rf[i] = in_Reg1;
        end
        if (reg_Write[3])  r3_log.push_back(in_Reg);
        if (reg_Write1[3]) r3_log.push_back(in_Reg1);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && pq.size() > 0; i++) idle();
        idle();
        check("drained", 32'(pend_Count), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we0"}, 32'(reg_Write),  32'(0));
        check({tag, "_d0"},  32'(in_Reg),     32'(0));
        check({tag, "_we1"}, 32'(reg_Write1), 32'(0));
        check({tag, "_d1"},  32'(in_Reg1),    32'(0));
        check({tag, "_cnt"}, 32'(pend_Count), 32'(0));
        check({tag, "_rdy"}, 32'(wb_Ready),   32'(1));
        check({tag, "_ovf"}, 32'(ovf_Err),    32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic av, mv;
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset_init");
        Rst_n = 1'b1;

        // Two different registers in one cycle use both ports
        step(1'b1, 3'd2, 16'h1234, 1'b1, 3'd5, 16'hBEEF);
        check("t2_we0", 32'(reg_Write),  32'h04);
        check("t2_d0",  32'(in_Reg),     32'h1234);
        check("t2_we1", 32'(reg_Write1), 32'h20);
        check("t2_d1",  32'(in_Reg1),    32'hBEEF);
        check("t2_cnt", 32'(pend_Count), 32'd0);

        // Same register: load deferred by one cycle
        step(1'b1, 3'd3, 16'h0001, 1'b1, 3'd3, 16'h0002);
        check("t3_we0", 32'(reg_Write),  32'h08);
        check("t3_d0",  32'(in_Reg),     32'h0001);
        check("t3_we1", 32'(reg_Write1), 32'h00);
        check("t3_cnt", 32'(pend_Count), 32'd1);
        idle();
        check("t3_we0b", 32'(reg_Write), 32'h08);
        check("t3_d0b",  32'(in_Reg),    32'h0002);
        check("t3_r3",   32'(rf[3]),     32'h0002);
        drain();

        // Repeated same-register pairs fill the FIFO and drain in order
        r3_log.delete();
        step(1'b1, 3'd3, 16'd1, 1'b1, 3'd3, 16'd2);
        step(1'b1, 3'd3, 16'd3, 1'b1, 3'd3, 16'd4);
        step(1'b1, 3'd3, 16'd5, 1'b1, 3'd3, 16'd6);
        check("t4_cnt", 32'(pend_Count), 32'd3);
        check("t4_rdy", 32'(wb_Ready),   32'd0);
        drain();
        check("t4_ovf", 32'(ovf_Err), 32'd0);
        check("t4_len", 32'(r3_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < r3_log.size(); i++)
            check("t4_order", 32'(r3_log[i]), 32'(i + 1));

        // Request while not ready is dropped and flagged
        step(1'b1, 3'd3, 16'd7, 1'b1, 3'd3, 16'd8);
        step(1'b1, 3'd3, 16'd9, 1'b1, 3'd3, 16'd10);
        step(1'b1, 3'd3, 16'd11, 1'b1, 3'd3, 16'd12);
        step(1'b1, 3'd6, 16'hDEAD, 1'b0, '0, '0);
        check("t5_ovf", 32'(ovf_Err), 32'd1);
        drain();
        check("t5_ovf_hold", 32'(ovf_Err), 32'd1);
        check("t5_r6", 32'(rf[6]), 32'd0);

        // Reset mid-stream with three writes pending
        step(1'b1, 3'd3, 16'd21, 1'b1, 3'd3, 16'd22);
        step(1'b1, 3'd3, 16'd23, 1'b1, 3'd3, 16'd24);
        step(1'b1, 3'd3, 16'd25, 1'b1, 3'd3, 16'd26);
        check("t1_cnt", 32'(pend_Count), 32'd3);
        alu_Valid = 1'b0; mem_Valid = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("t1_async");
        model_reset();
        @(posedge Clk);
        #1;
        check_reset_outputs("t1_clk");
        Rst_n = 1'b1;
        idle();

        // FIFO {r1,r1,r4}: r1 alone, then r1 with r4
        step(1'b1, 3'd1, 16'd1, 1'b1, 3'd1, 16'd2);
        step(1'b1, 3'd1, 16'd3, 1'b1, 3'd1, 16'd4);
        step(1'b1, 3'd1, 16'd5, 1'b1, 3'd4, 16'd6);
        idle();
        check("t6_we0a", 32'(reg_Write),  32'h02);
        check("t6_d0a",  32'(in_Reg),     32'd4);
        check("t6_we1a", 32'(reg_Write1), 32'h00);
        idle();
        check("t6_we0b", 32'(reg_Write),  32'h02);
        check("t6_d0b",  32'(in_Reg),     32'd5);
        check("t6_we1b", 32'(reg_Write1), 32'h10);
        check("t6_d1b",  32'(in_Reg1),    32'd6);
        drain();

        // Randomized traffic on a few registers to force collisions
        for (int n = 0; n < 400; n++) begin
            av = ($urandom_range(0, 99) < 60);
            mv = ($urandom_range(0, 99) < 60);
            if (!m_rdy && $urandom_range(0, 99) >= 3) begin av = 1'b0; mv = 1'b0; end
            step(av, ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
                 mv, ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
